// File: rtl/ctrl_pkg.sv
// Shared types for the fetch/decode sequencer: microaddresses, RV32 opcodes and FSM states.
package ctrl_pkg;

  typedef enum logic [4:0] {
    UA_NOP   = 5'd0,  UA_ADD   = 5'd1,  UA_SUB   = 5'd2,  UA_SLT   = 5'd3,
    UA_SLTU  = 5'd4,  UA_XOR   = 5'd5,  UA_OR    = 5'd6,  UA_AND   = 5'd7,
    UA_SLL   = 5'd8,  UA_SRL   = 5'd9,  UA_SRA   = 5'd10, UA_ADDI  = 5'd11,
    UA_SLTI  = 5'd12, UA_SLTIU = 5'd13, UA_XORI  = 5'd14, UA_ORI   = 5'd15,
    UA_ANDI  = 5'd16, UA_SLLI  = 5'd17, UA_SRLI  = 5'd18, UA_SRAI  = 5'd19,
    UA_LOAD  = 5'd20, UA_STORE = 5'd21, UA_BR_NT = 5'd22, UA_BR_T  = 5'd23,
    UA_JALR  = 5'd24, UA_MUL   = 5'd25
  } uaddr_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MUL_WAIT, MEM_WAIT} seq_state_t;

endpackage

// File: rtl/instr_decode_seq_if.sv
// Fetch, branch-compare, data-ready and controller-facing signals of the sequencer.
interface instr_decode_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            imemReq;
  logic            imemValid;
  logic [XLEN-1:0] imemRdata;
  logic            brEq;
  logic            brLt;
  logic            brLtu;
  logic            dmemReady;
  logic [4:0]      controlMemAddr;
  logic [XLEN-1:0] instrReg;
  logic            pcAdvance;
  logic            illegalInstr;
  logic            busy;

  modport master (
    output imemReq, controlMemAddr, instrReg, pcAdvance, illegalInstr, busy,
    input  imemValid, imemRdata, brEq, brLt, brLtu, dmemReady
  );

  modport slave (
    input  imemReq, controlMemAddr, instrReg, pcAdvance, illegalInstr, busy,
    output imemValid, imemRdata, brEq, brLt, brLtu, dmemReady
  );
endinterface

// File: rtl/udecode_rom.sv
// Combinational RV32I(+M) decode to a controller microaddress.
// DECODE_MUL_EN adds the mul encoding; otherwise it decodes as illegal.
module udecode_rom
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output uaddr_t      uaddr,
  output logic        is_branch,
  output logic        is_mul,
  output logic        is_load,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    uaddr = UA_NOP;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  uaddr = UA_ADD;
            3'b001:  uaddr = UA_SLL;
            3'b010:  uaddr = UA_SLT;
            3'b011:  uaddr = UA_SLTU;
            3'b100:  uaddr = UA_XOR;
            3'b101:  uaddr = UA_SRL;
            3'b110:  uaddr = UA_OR;
            default: uaddr = UA_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      uaddr = UA_SUB;
          else if (funct3 == 3'b101) uaddr = UA_SRA;
        end
`ifdef DECODE_MUL_EN
        else if (funct7 == F7_MULDIV && funct3 == 3'b000) begin
          uaddr = UA_MUL;
        end
`endif
      end
      OP_IMM: begin
        case (funct3)
          3'b000:  uaddr = UA_ADDI;
          3'b010:  uaddr = UA_SLTI;
          3'b011:  uaddr = UA_SLTIU;
          3'b100:  uaddr = UA_XORI;
          3'b110:  uaddr = UA_ORI;
          3'b111:  uaddr = UA_ANDI;
          3'b001:  uaddr = (funct7 == F7_BASE) ? UA_SLLI : UA_NOP;
          default: uaddr = (funct7 == F7_BASE) ? UA_SRLI :
                           (funct7 == F7_ALT)  ? UA_SRAI : UA_NOP;
        endcase
      end
      OP_LOAD:   if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) uaddr = UA_LOAD;
      OP_STORE:  if (funct3 inside {3'b000, 3'b001, 3'b010}) uaddr = UA_STORE;
      // Branches decode as not-taken; the taken/not-taken choice is made in EXEC.
      OP_BRANCH: if (!(funct3 inside {3'b010, 3'b011})) uaddr = UA_BR_NT;
      OP_JALR:   if (funct3 == 3'b000) uaddr = UA_JALR;
      default:   uaddr = UA_NOP;
    endcase
  end

  assign illegal   = (uaddr == UA_NOP);
  assign is_branch = (uaddr == UA_BR_NT);
  assign is_mul    = (uaddr == UA_MUL);
  assign is_load   = (uaddr == UA_LOAD);

endmodule

// File: rtl/instr_decode_seq.sv
// Fetch/decode sequencer feeding the microcoded controller one microaddress per step.
// DECODE_MUL_EN builds the MUL_WAIT state and its latency counter.
module instr_decode_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_decode_seq_if.master bus
);

  seq_state_t      state_q, state_d;
  logic [XLEN-1:0] instr_q;
  uaddr_t          uaddr_q;
  logic            branch_q;
  logic            illegal_q;
  logic            started_q;

  uaddr_t          dec_uaddr;
  logic            dec_branch, dec_mul, dec_load, dec_illegal;
  uaddr_t          ctrl_addr;
  logic            imem_req, pc_adv, taken;

  udecode_rom u_rom (
    .instr     (instr_q[31:0]),
    .uaddr     (dec_uaddr),
    .is_branch (dec_branch),
    .is_mul    (dec_mul),
    .is_load   (dec_load),
    .illegal   (dec_illegal)
  );

  always_comb begin
    case (instr_q[14:12])
      3'b000:  taken = bus.brEq;
      3'b001:  taken = !bus.brEq;
      3'b100:  taken = bus.brLt;
      3'b101:  taken = !bus.brLt;
      3'b110:  taken = bus.brLtu;
      3'b111:  taken = !bus.brLtu;
      default: taken = 1'b0;
    endcase
  end

`ifdef DECODE_MUL_EN
  localparam logic [3:0] MulWaitLast = 4'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == DECODE)                      cnt_d = MulWaitLast;
    else if (state_q == MUL_WAIT && cnt_q != 0) cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    ctrl_addr = UA_NOP;
    pc_adv    = 1'b0;
    unique case (state_q)
      FETCH: begin
        // Held off until the first edge after reset release.
        imem_req = started_q;
        if (started_q && bus.imemValid) state_d = DECODE;
      end
      DECODE: begin
        if (dec_mul)       state_d = (MUL_LATENCY > 1) ? MUL_WAIT : EXEC;
        else if (dec_load) state_d = MEM_WAIT;
        else               state_d = EXEC;
      end
`ifdef DECODE_MUL_EN
      MUL_WAIT: if (cnt_q == 0) state_d = EXEC;
`endif
      MEM_WAIT: begin
        ctrl_addr = UA_LOAD;
        if (bus.dmemReady) begin
          pc_adv  = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC: begin
        ctrl_addr = branch_q ? (taken ? UA_BR_T : UA_BR_NT) : uaddr_q;
        pc_adv    = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      instr_q   <= '0;
      uaddr_q   <= UA_NOP;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      if (state_q == FETCH && started_q && bus.imemValid) instr_q <= bus.imemRdata;
      if (state_q == DECODE) begin
        uaddr_q   <= dec_uaddr;
        branch_q  <= dec_branch;
        illegal_q <= illegal_q | dec_illegal;
      end
    end
  end

  assign bus.imemReq        = imem_req;
  assign bus.controlMemAddr = ctrl_addr;
  assign bus.instrReg       = instr_q;
  assign bus.pcAdvance      = pc_adv;
  assign bus.illegalInstr   = illegal_q;
  assign bus.busy           = (state_q != FETCH);

endmodule

// File: tb/tb_instr_decode_seq.sv
// Self-checking bench for instr_decode_seq: directed and randomized instructions vs. a cycle model.
module tb_instr_decode_seq;

  localparam int MulLat = 3;
`ifdef DECODE_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic sticky_ill;

  instr_decode_seq_if #(.XLEN(32)) bus ();

  instr_decode_seq #(.XLEN(32), .MUL_LATENCY(MulLat)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected microaddress straight from the decode table; 0 means illegal.
  function automatic int ref_uaddr(input logic [31:0] i, input logic eq, input logic lt,
                                   input logic ltu);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int r0[8];
    int im[8];
    logic cond;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    r0 = '{1, 8, 3, 4, 5, 9, 6, 7};
    im = '{11, 0, 12, 13, 14, 0, 15, 16};
    ref_uaddr = 0;
    case (op)
      7'b0110011: begin
        if (f7 == 7'd0) ref_uaddr = r0[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) ref_uaddr = 2;
        else if (f7 == 7'h20 && f3 == 3'd5) ref_uaddr = 10;
        else if (MulEn && f7 == 7'd1 && f3 == 3'd0) ref_uaddr = 25;
      end
      7'b0010011: begin
        if (f3 == 3'd1) ref_uaddr = (f7 == 7'd0) ? 17 : 0;
        else if (f3 == 3'd5) ref_uaddr = (f7 == 7'd0) ? 18 : (f7 == 7'h20) ? 19 : 0;
        else ref_uaddr = im[f3];
      end
      7'b0000011: if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) ref_uaddr = 20;
      7'b0100011: if (f3 <= 3'd2) ref_uaddr = 21;
      7'b1100011: begin
        if (f3 != 3'd2 && f3 != 3'd3) begin
          cond = (f3[2:1] == 2'd0) ? eq : (f3[2:1] == 2'd2) ? lt : ltu;
          ref_uaddr = 22 + int'(cond ^ f3[0]);
        end
      end
      7'b1100111: if (f3 == 3'd0) ref_uaddr = 24;
      default: ref_uaddr = 0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0, 6:    r[6:0] = 7'b0110011;
      1:       r[6:0] = 7'b0010011;
      2:       r[6:0] = 7'b0000011;
      3:       r[6:0] = 7'b0100011;
      4:       r[6:0] = 7'b1100011;
      5:       r[6:0] = 7'b1100111;
      default: r[6:0] = r[6:0];
    endcase
    case ($urandom_range(0, 3))
      0:       r[31:25] = 7'd0;
      1:       r[31:25] = 7'h20;
      2:       r[31:25] = 7'd1;
      default: r[31:25] = r[31:25];
    endcase
    return r;
  endfunction

  // Phases: 0 fetch idle, 1 fetch accept, 2 decode, 3 mul wait, 4 mem wait, 5 mem done, 6 exec.
  task automatic exec_instr(input string name, input logic [31:0] ins, input int fdly,
                            input int mwait, input logic eq, input logic lt, input logic ltu);
    int u;
    logic ill;
    int ph[$];
    int p;
    logic [4:0] e_addr;
    logic e_pc, e_busy, e_req, e_ill;
    u   = ref_uaddr(ins, eq, lt, ltu);
    ill = (u == 0);
    for (int k = 0; k < fdly; k++) ph.push_back(0);
    ph.push_back(1);
    ph.push_back(2);
    if (u == 25) for (int k = 0; k < MulLat - 1; k++) ph.push_back(3);
    if (u == 20) begin
      for (int k = 0; k < mwait; k++) ph.push_back(4);
      ph.push_back(5);
    end else begin
      ph.push_back(6);
    end
    for (int k = 0; k < ph.size(); k++) begin
      p = ph[k];
      bus.imemValid = (p == 1) ? 1'b1 : (p == 0) ? 1'b0 : 1'($urandom);
      bus.imemRdata = (p == 1) ? ins : $urandom;
      bus.dmemReady = (p == 4) ? 1'b0 : (p == 5) ? 1'b1 : 1'($urandom);
      bus.brEq      = (p == 6) ? eq  : 1'($urandom);
      bus.brLt      = (p == 6) ? lt  : 1'($urandom);
      bus.brLtu     = (p == 6) ? ltu : 1'($urandom);
      e_req  = (p <= 1);
      e_busy = (p >= 2);
      e_pc   = (p == 5 || p == 6);
      e_addr = (p == 4 || p == 5) ? 5'd20 : (p == 6) ? 5'(u) : 5'd0;
      e_ill  = (p >= 3) ? (sticky_ill | ill) : sticky_ill;
      @(negedge clk);
      n_checks++;
      if ({bus.controlMemAddr, bus.pcAdvance, bus.busy, bus.imemReq, bus.illegalInstr} !==
          {e_addr, e_pc, e_busy, e_req, e_ill}) begin
        n_fail++;
        $display("FAIL %s instr=%h cycle %0d phase %0d: got addr=%0d pc=%b busy=%b req=%b ill=%b, want addr=%0d pc=%b busy=%b req=%b ill=%b",
                 name, ins, k, p, bus.controlMemAddr, bus.pcAdvance, bus.busy, bus.imemReq,
                 bus.illegalInstr, e_addr, e_pc, e_busy, e_req, e_ill);
      end
      if (p >= 2) begin
        n_checks++;
        if (bus.instrReg !== ins) begin
          n_fail++;
          $display("FAIL %s instrReg cycle %0d: got %h want %h", name, k, bus.instrReg, ins);
        end
      end
      @(posedge clk);
      #1;
    end
    sticky_ill = sticky_ill | ill;
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({bus.imemReq, bus.controlMemAddr, bus.instrReg, bus.pcAdvance, bus.illegalInstr,
         bus.busy} !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs req=%b addr=%0d instr=%h pc=%b ill=%b busy=%b, want all 0",
               name, bus.imemReq, bus.controlMemAddr, bus.instrReg, bus.pcAdvance,
               bus.illegalInstr, bus.busy);
    end
  endtask

  task automatic release_reset(input string name);
    rst_n = 1'b1;
    n_checks++;
    if (bus.imemReq !== 1'b0) begin
      n_fail++;
      $display("FAIL %s req before edge: got %b want 0", name, bus.imemReq);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.imemReq, bus.busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s req after edge: got req=%b busy=%b want req=1 busy=0", name,
               bus.imemReq, bus.busy);
    end
    sticky_ill = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    check_all_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_held");
    release_reset("reset_release");
  endtask

  task automatic test_alu();
    exec_instr("add", 32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0);
    exec_instr("sub", 32'h402081B3, 1, 0, 1'b0, 1'b0, 1'b0);
    exec_instr("srai", 32'h4030D193, 0, 0, 1'b0, 1'b0, 1'b0);
    exec_instr("store", 32'h0030A223, 2, 0, 1'b0, 1'b0, 1'b0);
    exec_instr("jalr", 32'h000080E7, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_branch();
    exec_instr("beq_taken", 32'h00208463, 0, 0, 1'b1, 1'b0, 1'b0);
    exec_instr("beq_not", 32'h00208463, 0, 0, 1'b0, 1'b1, 1'b1);
    exec_instr("bne_eq", 32'h00209463, 0, 0, 1'b1, 1'b0, 1'b0);
    exec_instr("bgeu_taken", 32'h0020F463, 0, 0, 1'b0, 1'b1, 1'b0);
    exec_instr("blt_taken", 32'h0020C463, 0, 0, 1'b0, 1'b1, 1'b0);
    exec_instr("bge_not", 32'h0020D463, 0, 0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_mul();
    exec_instr("mul", 32'h022081B3, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_load();
    exec_instr("lw_wait3", 32'h0000A183, 0, 3, 1'b0, 1'b0, 1'b0);
    exec_instr("lb_nowait", 32'h00008183, 1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    exec_instr("illegal_ff", 32'hFFFFFFFF, 0, 0, 1'b0, 1'b0, 1'b0);
    exec_instr("addi_after_ill", 32'h00100093, 0, 0, 1'b0, 1'b0, 1'b0);
    exec_instr("branch_f3_010", 32'h0020A463, 0, 0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    exec_instr("b2b_0", 32'h0020F1B3, 0, 0, 1'b0, 1'b0, 1'b0);
    exec_instr("b2b_1", 32'h0000A183, 0, 0, 1'b0, 1'b0, 1'b0);
    exec_instr("b2b_2", 32'h00208463, 0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      exec_instr("random", rand_instr(), $urandom_range(0, 2), $urandom_range(0, 4),
                 1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_async_reset();
    bus.imemValid = 1'b1;
    bus.imemRdata = 32'h0000A183;
    bus.dmemReady = 1'b0;
    @(posedge clk);
    #1;
    bus.imemValid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.controlMemAddr, bus.busy} !== {5'd20, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_mem_wait entry: got addr=%0d busy=%b want addr=20 busy=1",
               bus.controlMemAddr, bus.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid_mem_wait");
    @(posedge clk);
    #1;
    check_all_zero("rst_mid_held");
    release_reset("rst_mid_release");
    exec_instr("addi_after_rst", 32'h00100093, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    sticky_ill    = 1'b0;
    rst_n         = 1'b0;
    bus.imemValid = 1'b0;
    bus.imemRdata = '0;
    bus.brEq      = 1'b0;
    bus.brLt      = 1'b0;
    bus.brLtu     = 1'b0;
    bus.dmemReady = 1'b0;
    test_reset();
    test_alu();
    test_branch();
    test_mul();
    test_load();
    test_illegal();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
